// File: rtl/wired_cdb_tx.sv
// rtl/wired_cdb_tx.sv - CDB transmitter FIFO; cdb bus = {valid, wid[WID_W], data[DATA_W]}, valid at MSB.
// Optional same-cycle bypass of an empty FIFO: define WIRED_CDB_TX_BYPASS_EN.
module wired_cdb_tx #(
    parameter int  DEPTH   = 4,
    parameter int  STALL_W = 8,
    parameter int  WID_W   = 6,
    parameter int  DATA_W  = 32,
    localparam int CDB_W   = 1 + WID_W + DATA_W,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               fu_valid_i,
    input  logic [CDB_W-1:0]   fu_cdb_i,
    output logic               fu_ready_o,
    output logic [CDB_W-1:0]   cdb_o,
    input  logic               cdb_ready_i,
    output logic [CNT_W-1:0]   count_o,
    output logic [STALL_W-1:0] stall_cnt_o
);

    localparam int PAY_W = CDB_W - 1;

    logic [PAY_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic               cdb_valid;
    logic [PAY_W-1:0]   cdb_payload;
    logic               bypass;
    logic               push;
    logic               pop_fifo;

    // The FU's own valid field is superseded by fu_valid_i.
    logic unused_fu_valid_field;
    assign unused_fu_valid_field = fu_cdb_i[CDB_W-1];

    assign fu_ready_o = (count_q < CNT_W'(DEPTH));

    always_comb begin
        bypass      = 1'b0;
        cdb_valid   = (count_q != '0) && !flush_i;
        cdb_payload = mem_q[rd_ptr_q];
`ifdef WIRED_CDB_TX_BYPASS_EN
        bypass = (count_q == '0) && fu_valid_i && !flush_i;
        if (bypass) begin
            cdb_valid   = 1'b1;
            cdb_payload = fu_cdb_i[PAY_W-1:0];
        end
`endif
    end

    assign cdb_o = {cdb_valid, cdb_payload};

    // A bypassed result that the arbiter takes right away never enters the FIFO.
    assign push     = fu_valid_i && fu_ready_o && !flush_i && !(bypass && cdb_ready_i);
    assign pop_fifo = (count_q != '0) && !flush_i && cdb_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stall_d  = '0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_fifo) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop_fifo})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (cdb_valid && !cdb_ready_i)
                stall_d = (stall_q == '1) ? stall_q : stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Payload storage carries no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= fu_cdb_i[PAY_W-1:0];
    end

    assign count_o     = count_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_wired_cdb_tx.sv
// tb/tb_wired_cdb_tx.sv - directed self-checking bench for wired_cdb_tx (DEPTH=4, STALL_W=8).
module tb_wired_cdb_tx;

    localparam int WID_W  = 6;
    localparam int DATA_W = 32;
    localparam int CDB_W  = 1 + WID_W + DATA_W;

    logic             clk;
    logic             rst_n;
    logic             flush_i;
    logic             fu_valid_i;
    logic [CDB_W-1:0] fu_cdb_i;
    logic             fu_ready_o;
    logic [CDB_W-1:0] cdb_o;
    logic             cdb_ready_i;
    logic [2:0]       count_o;
    logic [7:0]       stall_cnt_o;

    int checks = 0;
    int errors = 0;

    wired_cdb_tx #(.DEPTH(4), .STALL_W(8), .WID_W(WID_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .fu_valid_i  (fu_valid_i),
        .fu_cdb_i    (fu_cdb_i),
        .fu_ready_o  (fu_ready_o),
        .cdb_o       (cdb_o),
        .cdb_ready_i (cdb_ready_i),
        .count_o     (count_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic ok, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CDB_W-1:0] mk(input int wid, input int data);
        return {1'b1, WID_W'(wid), DATA_W'(data)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [CDB_W-1:0] A = {1'b1, 6'd1, 32'hA0};
    localparam logic [CDB_W-1:0] E = {1'b1, 6'd5, 32'hA4};

`ifdef WIRED_CDB_TX_BYPASS_EN
    localparam int STALL_AFTER_FILL = 5;
`else
    localparam int STALL_AFTER_FILL = 4;
`endif

    logic [CDB_W-1:0] offers [7];
    logic [CDB_W-1:0] outs   [7];
    logic [CDB_W-1:0] exp_pp;

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; fu_valid_i = 1'b0; fu_cdb_i = '0; cdb_ready_i = 1'b0;
        #3;
        chk("reset_count", count_o === 3'd0, count_o, 0);
        chk("reset_stall", stall_cnt_o === 8'd0, stall_cnt_o, 0);
        chk("reset_ready", fu_ready_o === 1'b1, fu_ready_o, 1);
        chk("reset_valid", cdb_o[CDB_W-1] === 1'b0, cdb_o[CDB_W-1], 0);
        step();
        rst_n = 1'b1;
        step();

        fu_valid_i = 1'b1; fu_cdb_i = mk(5, 32'h1111); cdb_ready_i = 1'b1;
        #1;
`ifdef WIRED_CDB_TX_BYPASS_EN
        chk("single_bypass", cdb_o === mk(5, 32'h1111), cdb_o, mk(5, 32'h1111));
        step();
        fu_valid_i = 1'b0;
        #1;
        chk("single_bypass_count", count_o === 3'd0, count_o, 0);
        chk("single_bypass_valid", cdb_o[CDB_W-1] === 1'b0, cdb_o[CDB_W-1], 0);
`else
        chk("single_no_same_cycle", cdb_o[CDB_W-1] === 1'b0, cdb_o[CDB_W-1], 0);
        step();
        fu_valid_i = 1'b0;
        #1;
        chk("single_out", cdb_o === mk(5, 32'h1111), cdb_o, mk(5, 32'h1111));
        chk("single_count1", count_o === 3'd1, count_o, 1);
        step();
        chk("single_count0", count_o === 3'd0, count_o, 0);
        chk("single_valid0", cdb_o[CDB_W-1] === 1'b0, cdb_o[CDB_W-1], 0);
`endif

        cdb_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fu_valid_i = 1'b1; fu_cdb_i = mk(i + 1, 32'hA0 + i);
            #1;
            chk("fill_ready", fu_ready_o === (i < 4), fu_ready_o, (i < 4));
            step();
        end
        fu_valid_i = 1'b0;
        #1;
        chk("full_count", count_o === 3'd4, count_o, 4);
        chk("full_ready", fu_ready_o === 1'b0, fu_ready_o, 0);
        chk("full_head", cdb_o === A, cdb_o, A);
        chk("full_stall", stall_cnt_o === 8'(STALL_AFTER_FILL), stall_cnt_o, STALL_AFTER_FILL);
        step();
        chk("stall_inc", stall_cnt_o === 8'(STALL_AFTER_FILL + 1), stall_cnt_o, STALL_AFTER_FILL + 1);
        chk("head_stable", cdb_o === A, cdb_o, A);
        repeat (300) step();
        chk("stall_sat", stall_cnt_o === 8'd255, stall_cnt_o, 255);
        chk("head_stable_long", cdb_o === A, cdb_o, A);
        chk("e_dropped_count", count_o === 3'd4, count_o, 4);

        offers[0] = mk(6, 32'hB0); offers[1] = mk(6, 32'hB0); offers[2] = mk(7, 32'hB1);
        offers[3] = mk(8, 32'hB2); offers[4] = mk(9, 32'hB3); offers[5] = mk(10, 32'hB4);
        offers[6] = mk(11, 32'hB5);
        outs[0] = A; outs[1] = mk(2, 32'hA1); outs[2] = mk(3, 32'hA2); outs[3] = mk(4, 32'hA3);
        outs[4] = mk(6, 32'hB0); outs[5] = mk(7, 32'hB1); outs[6] = mk(8, 32'hB2);
        cdb_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            fu_valid_i = 1'b1; fu_cdb_i = offers[i];
            #1;
            chk("drain_order", cdb_o === outs[i], cdb_o, outs[i]);
            chk("drain_no_dup_e", cdb_o !== E, cdb_o, E);
            if (i == 1) begin
                chk("drain_stall_clr", stall_cnt_o === 8'd0, stall_cnt_o, 0);
                chk("drain_count", count_o === 3'd3, count_o, 3);
            end
            step();
        end
        fu_valid_i = 1'b0;
        #1;
        chk("pop_to_two", cdb_o === mk(9, 32'hB3), cdb_o, mk(9, 32'hB3));
        step();
        chk("count_two", count_o === 3'd2, count_o, 2);

        for (int i = 0; i < 10; i++) begin
            fu_valid_i = 1'b1; fu_cdb_i = mk(20 + i, 32'hC0 + i);
            #1;
            if (i == 0) exp_pp = mk(10, 32'hB4);
            else if (i == 1) exp_pp = mk(11, 32'hB5);
            else exp_pp = mk(18 + i, 32'hBE + i);
            chk("pp_order", cdb_o === exp_pp, cdb_o, exp_pp);
            step();
            chk("pp_count", count_o === 3'd2, count_o, 2);
        end

        cdb_ready_i = 1'b0; fu_cdb_i = mk(30, 32'hD0);
        step();
        chk("pre_flush_count", count_o === 3'd3, count_o, 3);
        flush_i = 1'b1; fu_valid_i = 1'b1; fu_cdb_i = mk(31, 32'hD1); cdb_ready_i = 1'b1;
        #1;
        chk("flush_valid", cdb_o[CDB_W-1] === 1'b0, cdb_o[CDB_W-1], 0);
        step();
        flush_i = 1'b0; fu_valid_i = 1'b0;
        #1;
        chk("post_flush_count", count_o === 3'd0, count_o, 0);
        chk("post_flush_valid", cdb_o[CDB_W-1] === 1'b0, cdb_o[CDB_W-1], 0);
        chk("post_flush_stall", stall_cnt_o === 8'd0, stall_cnt_o, 0);

        cdb_ready_i = 1'b0; fu_valid_i = 1'b1;
        fu_cdb_i = mk(40, 32'hE0);
        step();
        fu_cdb_i = mk(41, 32'hE1);
        step();
        fu_valid_i = 1'b0;
        #1;
        chk("pre_rst_count", count_o === 3'd2, count_o, 2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", count_o === 3'd0, count_o, 0);
        chk("async_rst_valid", cdb_o[CDB_W-1] === 1'b0, cdb_o[CDB_W-1], 0);
        chk("async_rst_ready", fu_ready_o === 1'b1, fu_ready_o, 1);
        chk("async_rst_stall", stall_cnt_o === 8'd0, stall_cnt_o, 0);
        step();
        rst_n = 1'b1;
        fu_valid_i = 1'b1; fu_cdb_i = mk(42, 32'hE2);
        step();
        fu_valid_i = 1'b0;
        #1;
        chk("after_rst_head", cdb_o === mk(42, 32'hE2), cdb_o, mk(42, 32'hE2));
        chk("after_rst_count", count_o === 3'd1, count_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
